// File: rtl/score_pkg.sv
// Shared definitions for the score display: FSM encoding and seven-segment patterns.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } stateT;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segment patterns for digits 0..9, bit0 = segment a.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/score_display_seg7_decode.sv
// BCD digit to active-low seven-segment decoder with a blank override.
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Codes above 9 cannot come from a valid conversion; show them blank.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/score_display.sv
// Iterative double-dabble conversion of the game score onto three HEX digits,
// with a load/busy/done handshake and a single-entry latest-value pending slot.
module score_display
  import score_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      score_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [1:0]            dbgState
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: load is sampled on every rising edge. A load accepted while
  // busy=1 (including the LATCH cycle) replaces any stored request; done pulses
  // for one cycle when bcd/hex change, and busy stays high across a restart.

  stateT                state, nextState;
  logic [WIDTH-1:0]     binReg;
  logic [4*DIGITS-1:0]  acc;
  logic [4*DIGITS-1:0]  adj;
  logic [CW-1:0]        cnt;
  logic                 pending;
  logic [WIDTH-1:0]     pendScore;

  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (load) nextState = SHIFT;
      SHIFT:   if (cnt == CW'(1)) nextState = LATCH;
      LATCH:   nextState = (load || pending) ? SHIFT : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      binReg    <= '0;
      acc       <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      pendScore <= '0;
      bcd       <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == LATCH);
      case (state)
        IDLE: begin
          if (load) begin
            binReg <= score_in;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          {acc, binReg} <= {adj[4*DIGITS-2:0], binReg, 1'b0};
          cnt           <= cnt - CW'(1);
          if (load) begin
            pendScore <= score_in;
            pending   <= 1'b1;
          end
        end
        LATCH: begin
          bcd <= acc;
          // A load landing in this cycle is newer than anything stored.
          if (load || pending) begin
            binReg  <= load ? score_in : pendScore;
            acc     <= '0;
            cnt     <= CW'(WIDTH);
            pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE) || pending;
  assign dbgState = state;

  logic blankHund, blankTens;
  assign blankHund = (BLANK_LEADING != 0) && (bcd[11:8] == 4'd0);
  assign blankTens = blankHund && (bcd[7:4] == 4'd0);

  seg7_decode u_dec0 (.digit(bcd[3:0]),  .blank(1'b0),      .seg(hex0));
  seg7_decode u_dec1 (.digit(bcd[7:4]),  .blank(blankTens), .seg(hex1));
  seg7_decode u_dec2 (.digit(bcd[11:8]), .blank(blankHund), .seg(hex2));

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: directed handshake scenarios plus random bursts,
// checked by a done-triggered monitor against an arithmetic digit model.
module tb_score_display;

  logic        clk;
  logic        resetn;
  logic [7:0]  score_in;
  logic        load;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  hex0, hex1, hex2;
  logic [1:0]  dbgState;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int doneCount = 0;
  int lastDoneCyc = 0;
  int loadEdge = 0;
  logic [7:0] lastShown = 8'd0;
  logic       anyShown = 1'b0;
  logic [7:0] exp_q[$];

  score_display #(.WIDTH(8), .DIGITS(3), .BLANK_LEADING(1)) dut (
    .clk(clk), .resetn(resetn), .score_in(score_in), .load(load),
    .busy(busy), .done(done), .bcd(bcd),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] modelBcd(input logic [7:0] s);
    int v;
    v = s;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] modelHex(input logic [7:0] s, input int pos);
    int v, h, t, o;
    v = s; h = v / 100; t = (v / 10) % 10; o = v % 10;
    if (pos == 0) return segOf(o);
    if (pos == 1) return (h == 0 && t == 0) ? 7'b1111111 : segOf(t);
    return (h == 0) ? 7'b1111111 : segOf(h);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkDisplay(input string tag, input logic [7:0] s);
    check({tag, "_bcd"},  32'(bcd),  32'(modelBcd(s)));
    check({tag, "_hex0"}, 32'(hex0), 32'(modelHex(s, 0)));
    check({tag, "_hex1"}, 32'(hex1), 32'(modelHex(s, 1)));
    check({tag, "_hex2"}, 32'(hex2), 32'(modelHex(s, 2)));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn && done) begin
      doneCount++;
      lastDoneCyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        lastShown = exp_q.pop_front();
        anyShown  = 1'b1;
        checkDisplay("done", lastShown);
      end
    end
  end

  // driver tasks
  task automatic doLoad(input logic [7:0] v);
    score_in = v;
    load     = 1'b1;
    @(posedge clk);
    #1;
    loadEdge = cyc;
    load     = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle_reached"}, 32'(ok), 32'd1);
    if (ok && anyShown) checkDisplay({tag, "_hold"}, lastShown);
  endtask

  // busy must stay high at every sample until doneCount reaches target
  task automatic watchBusy(input string tag, input int target, output int highCnt);
    int lowSeen;
    logic reached;
    lowSeen = 0; highCnt = 0; reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (doneCount >= target) begin
        reached = 1'b1;
        break;
      end
      if (busy) highCnt++; else lowSeen++;
    end
    check({tag, "_done_seen"}, 32'(reached), 32'd1);
    check({tag, "_busy_gap"}, 32'(lowSeen), 32'd0);
  endtask

  initial begin
    int d0, hi, k;
    logic [7:0] a, last;

    resetn = 1'b0; load = 1'b0; score_in = 8'd0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbgState), 32'd0);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_bcd", 32'(bcd), 32'h000);
    check("idle_hex0", 32'(hex0), 32'b1000000);
    check("idle_hex1", 32'(hex1), 32'b1111111);
    check("idle_hex2", 32'(hex2), 32'b1111111);
    check("idle_busy", 32'(busy), 32'd0);

    // single conversion: latency and busy width
    d0 = doneCount;
    exp_q.push_back(8'd173);
    doLoad(8'd173);
    watchBusy("s173", d0 + 1, hi);
    check("s173_busy_cycles", 32'(hi), 32'd9);
    check("s173_latency", 32'(lastDoneCyc - loadEdge), 32'd9);
    waitIdle("s173");

    // loads while busy: 7 dropped, 42 kept
    d0 = doneCount;
    exp_q.push_back(8'd5);
    doLoad(8'd5);
    repeat (2) @(posedge clk);
    #1;
    doLoad(8'd7);
    doLoad(8'd42);
    exp_q.push_back(8'd42);
    watchBusy("p42", d0 + 2, hi);
    waitIdle("p42");
    check("p42_done_count", 32'(doneCount - d0), 32'd2);

    // second load lands exactly in the LATCH cycle
    d0 = doneCount;
    exp_q.push_back(8'd9);
    doLoad(8'd9);
    repeat (8) @(posedge clk);
    #1;
    exp_q.push_back(8'd255);
    doLoad(8'd255);
    watchBusy("b255", d0 + 2, hi);
    waitIdle("b255");
    check("b255_done_count", 32'(doneCount - d0), 32'd2);

    // boundaries and wrapped value
    foreach (exp_q[i]) ;
    a = 8'd0 - 8'd5;
    exp_q.push_back(a);
    doLoad(a);
    waitIdle("wrap251");
    exp_q.push_back(8'd40);
    doLoad(8'd40);
    waitIdle("s40");
    exp_q.push_back(8'd0);
    doLoad(8'd0);
    waitIdle("s0");
    exp_q.push_back(8'd100);
    doLoad(8'd100);
    waitIdle("s100");

    // reset during conversion of 200
    exp_q.push_back(8'd200);
    doLoad(8'd200);
    repeat (4) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    anyShown = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'h000);
    check("mid_rst_hex0", 32'(hex0), 32'b1000000);
    check("mid_rst_hex1", 32'(hex1), 32'b1111111);
    check("mid_rst_hex2", 32'(hex2), 32'b1111111);
    d0 = doneCount;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(doneCount - d0), 32'd0);
    check("mid_rst_busy_after", 32'(busy), 32'd0);
    exp_q.push_back(8'd200);
    doLoad(8'd200);
    waitIdle("s200");

    // random singles and bursts; a burst displays its first and last values
    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom_range(0, 255));
      exp_q.push_back(a);
      doLoad(a);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, 3);
        last = 8'd0;
        for (int j = 0; j < k; j++) begin
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
          end
          last = 8'($urandom_range(0, 255));
          doLoad(last);
        end
        exp_q.push_back(last);
      end
      waitIdle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
